// File: rtl/rd_burst_consumer.sv
// -----------------------------------------------------------------------------
// rd_burst_consumer
//
// Read-domain consumer for the async FIFO. On a request it pulls a burst of
// 1..BURST_LEN words through the FIFO read port and presents them downstream
// on a valid/ready interface. Downstream back-pressure is absorbed by a
// 2-entry skid buffer. A one-cycle `done` pulse marks the final transfer.
//
// Optional feature macro: RD_CONSUMER_STATS_EN
//   When defined, adds the `words_delivered` port, a saturating 16-bit count
//   of downstream transfers since reset. When undefined, the port and the
//   counter do not exist; all other behaviour is identical.
//
// Parameters
//   DATA_WIDTH : word width of FIFO data and dout
//   BURST_LEN  : maximum words per burst (>= 1)
//   LEN_W      : width of rd_len
//
// Ports
//   r_clk           in   read-domain clock
//   rrst            in   asynchronous active-low reset
//   rd_req          in   burst request, sampled only while idle
//   rd_len          in   words requested (0 or > BURST_LEN means BURST_LEN)
//   f_empty         in   FIFO empty flag, synchronous to r_clk
//   mem_data_out    in   FIFO read data, valid the cycle after r_en
//   r_en            out  FIFO read enable, one word per high cycle
//   dout            out  head word of the skid buffer
//   dout_valid      out  dout holds a word
//   dout_ready      in   downstream accepts (transfer = dout_valid & dout_ready)
//   busy            out  high while a burst is being read or drained
//   done            out  one-cycle pulse after the last word of a burst
//   words_delivered out  transfer counter (RD_CONSUMER_STATS_EN only)
// -----------------------------------------------------------------------------
module rd_burst_consumer #(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int LEN_W      = $clog2(BURST_LEN + 1)
) (
   input  logic                  r_clk,
   input  logic                  rrst,
   input  logic                  rd_req,
   input  logic [LEN_W-1:0]      rd_len,
   input  logic                  f_empty,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  r_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  busy,
   output logic                  done
`ifdef RD_CONSUMER_STATS_EN
   ,
   output logic [15:0]           words_delivered
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int              SKID_DEPTH = 2;
   localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(BURST_LEN);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]            state_reg, state_next;
   logic [LEN_W-1:0]      rem_reg,   rem_next;    // words still to issue
   logic [LEN_W-1:0]      left_reg,  left_next;   // words not yet transferred
   logic [1:0]            occ_reg,   occ_next;    // skid buffer occupancy
   logic                  inflight_reg;           // r_en was high last cycle
   logic                  done_reg,  done_next;

   logic [DATA_WIDTH-1:0] skid_q [SKID_DEPTH];    // skid_q[0] is the head

   logic                  pop;
   logic                  push;
   logic [2:0]            credit_used;
   logic [1:0]            wr_idx;
   logic [LEN_W-1:0]      eff_len;

   // ------------------------------------------------------------------
   // Handshake and read-issue logic
   // ------------------------------------------------------------------
   assign dout_valid = (occ_reg != 2'd0);
   assign dout       = skid_q[0];
   assign pop        = dout_valid && dout_ready;
   assign push       = inflight_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign done       = done_reg;

   // Slots that will be occupied after this cycle if no new read is issued:
   // the word already in flight reserves a slot, a pop this cycle frees one.
   // Issuing only while this is below the buffer depth is what keeps the
   // skid buffer from ever overflowing.
   assign credit_used = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};

   assign r_en = (state_reg == ST_READ) && !f_empty && (rem_reg != '0) &&
                 (credit_used < 3'(SKID_DEPTH));

   // Out-of-range lengths (0 or above the maximum) fall back to a full burst.
   assign eff_len = ((rd_len == '0) || (rd_len > MAX_LEN)) ? MAX_LEN : rd_len;

   // Tail position for an incoming word: after a simultaneous pop the
   // remaining entries have shifted down by one.
   assign wr_idx = occ_reg - {1'b0, pop};

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      rem_next   = rem_reg;
      left_next  = left_reg;
      done_next  = 1'b0;

      if (pop && (left_reg != '0)) begin
         left_next = left_reg - 1'b1;
      end

      case (state_reg)
         ST_IDLE: begin
            if (rd_req) begin
               rem_next   = eff_len;
               left_next  = eff_len;
               state_next = ST_READ;
            end
         end

         ST_READ: begin
            if (r_en) begin
               rem_next = rem_reg - 1'b1;
               // Leave READ on the same edge that issues the final read.
               if (rem_reg == LEN_W'(1)) begin
                  state_next = ST_DRAIN;
               end
            end else if (rem_reg == '0) begin
               state_next = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // The last word can only reach the buffer after the final read,
            // so the closing transfer always happens here.
            if (pop && (left_reg == LEN_W'(1))) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Skid buffer occupancy
   // ------------------------------------------------------------------
   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 2'd1;
         2'b01:   occ_next = occ_reg - 2'd1;
         default: occ_next = occ_reg;
      endcase
   end

   // ------------------------------------------------------------------
   // Sequential control state
   // ------------------------------------------------------------------
   always_ff @(posedge r_clk or negedge rrst) begin
      if (!rrst) begin
         state_reg    <= ST_IDLE;
         rem_reg      <= '0;
         left_reg     <= '0;
         occ_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rem_reg      <= rem_next;
         left_reg     <= left_next;
         occ_reg      <= occ_next;
         inflight_reg <= r_en;
         done_reg     <= done_next;
      end
   end

   // ------------------------------------------------------------------
   // Skid buffer storage. Each slot either takes the incoming FIFO word
   // (when it is the tail position), shifts down from the slot above on a
   // pop, or holds. Holding slot 0 while not popped keeps dout stable under
   // back-pressure.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
         localparam logic [1:0] SLOT_IDX = 2'(gi);

         logic [DATA_WIDTH-1:0] slot_reg;
         logic [DATA_WIDTH-1:0] slot_next;

         if (gi < SKID_DEPTH - 1) begin : g_shift
            always_comb begin
               slot_next = slot_reg;
               if (push && (wr_idx == SLOT_IDX)) begin
                  slot_next = mem_data_out;
               end else if (pop) begin
                  slot_next = skid_q[gi + 1];
               end
            end
         end else begin : g_tail
            always_comb begin
               slot_next = slot_reg;
               if (push && (wr_idx == SLOT_IDX)) begin
                  slot_next = mem_data_out;
               end
            end
         end

         always_ff @(posedge r_clk or negedge rrst) begin
            if (!rrst) begin
               slot_reg <= '0;
            end else begin
               slot_reg <= slot_next;
            end
         end

         assign skid_q[gi] = slot_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Optional delivery counter
   // ------------------------------------------------------------------
`ifdef RD_CONSUMER_STATS_EN
   logic [15:0] words_reg;

   always_ff @(posedge r_clk or negedge rrst) begin
      if (!rrst) begin
         words_reg <= 16'd0;
      end else if (pop && (words_reg != 16'hFFFF)) begin
         words_reg <= words_reg + 16'd1;
      end
   end

   assign words_delivered = words_reg;
`endif

endmodule

// File: tb/tb_rd_burst_consumer.sv
// -----------------------------------------------------------------------------
// tb_rd_burst_consumer
//
// Scoreboard bench for rd_burst_consumer. The stimulus process loads a FIFO
// model, pushes the expected delivered words (with a last-of-burst marker)
// into a queue and raises rd_req. A monitor on the falling edge pops the
// queue on every downstream transfer, checks data order, the done pulse and
// reset outputs, and keeps r_en / busy / transfer counters that the stimulus
// checks against hand-computed numbers. Inputs change 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rd_burst_consumer;

   localparam int DW = 32;
   localparam int BL = 4;
   localparam int LW = $clog2(BL + 1);

   logic          r_clk;
   logic          rrst;
   logic          rd_req;
   logic [LW-1:0] rd_len;
   logic          f_empty;
   logic [DW-1:0] mem_data_out;
   logic          r_en;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          busy;
   logic          done;
`ifdef RD_CONSUMER_STATS_EN
   logic [15:0]   words_delivered;
`endif

   rd_burst_consumer #(
      .DATA_WIDTH(DW),
      .BURST_LEN (BL)
   ) dut (
      .r_clk       (r_clk),
      .rrst        (rrst),
      .rd_req      (rd_req),
      .rd_len      (rd_len),
      .f_empty     (f_empty),
      .mem_data_out(mem_data_out),
      .r_en        (r_en),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .busy        (busy),
      .done        (done)
`ifdef RD_CONSUMER_STATS_EN
      ,
      .words_delivered(words_delivered)
`endif
   );

   initial begin
      r_clk = 1'b0;
      forever #5 r_clk = ~r_clk;
   end

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] fifo_q[$];
   int            fifo_cnt = 0;
   logic          force_empty = 1'b0;
   bit            take = 1'b0;

   int vectors    = 0;
   int miscompares = 0;

   int cyc        = 0;
   int r_en_cnt   = 0;
   int busy_cnt   = 0;
   int run_len    = 0;
   int max_run    = 0;
   int xfer_cnt   = 0;
   int first_xfer = -1;
   int last_xfer  = -1;
   bit done_exp   = 1'b0;

   assign f_empty = force_empty | (fifo_cnt == 0);

   // FIFO model: a word read in cycle M appears on mem_data_out in M+1.
   initial begin
      mem_data_out = '0;
      forever begin
         @(negedge r_clk);
         take = r_en && rrst;
         @(posedge r_clk);
         #1;
         if (take && fifo_q.size() > 0) mem_data_out = fifo_q.pop_front();
         fifo_cnt = fifo_q.size();
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge r_clk);
         cyc++;
         if (!rrst) begin
            vectors++;
            if (r_en !== 1'b0 || dout !== '0 || dout_valid !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_outputs: r_en=%0b dout=%h dout_valid=%0b busy=%0b done=%0b, required all zero",
                        r_en, dout, dout_valid, busy, done);
            end
            done_exp = 1'b0;
            run_len  = 0;
         end else begin
            if (done || done_exp) begin
               vectors++;
               if (done !== done_exp) begin
                  miscompares++;
                  $display("FAIL done_pulse: cycle %0d done=%0b required %0b", cyc, done, done_exp);
               end
            end
            done_exp = 1'b0;
            if (r_en) begin
               r_en_cnt++;
               run_len++;
               if (run_len > max_run) max_run = run_len;
            end else begin
               run_len = 0;
            end
            if (busy) busy_cnt++;
            if (dout_valid && dout_ready) begin
               xfer_cnt++;
               if (first_xfer < 0) first_xfer = cyc;
               last_xfer = cyc;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_word: got %h, required no transfer", dout);
               end else begin
                  e = exp_q.pop_front();
                  if (dout !== e.data) begin
                     miscompares++;
                     $display("FAIL word_data: got %h required %h", dout, e.data);
                  end
                  done_exp = e.last;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic clear_stats();
      r_en_cnt   = 0;
      busy_cnt   = 0;
      max_run    = 0;
      xfer_cnt   = 0;
      first_xfer = -1;
      last_xfer  = -1;
   endtask

   task automatic flush_fifo();
      fifo_q.delete();
      fifo_cnt = 0;
   endtask

   // Loads nfifo words base, base+1, ... and requests a burst of len.
   task automatic issue(input int len, input logic [DW-1:0] base, input int nfifo);
      int   eff;
      exp_t e;
      eff = (len == 0 || len > BL) ? BL : len;
      for (int i = 0; i < nfifo; i++) fifo_q.push_back(base + DW'(i));
      fifo_cnt = fifo_q.size();
      for (int i = 0; i < eff; i++) begin
         e.data = base + DW'(i);
         e.last = (i == eff - 1);
         exp_q.push_back(e);
      end
      rd_req = 1'b1;
      rd_len = LW'(len);
      tick();
      rd_req = 1'b0;
      $display("burst len=%0d base=%h effective=%0d", len, base, eff);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 80) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 80) begin
         miscompares++;
         $display("FAIL %s_timeout: %0d words outstanding, required 0", tag, exp_q.size());
      end
      tick();
   endtask

   task automatic pulse_reset();
      rrst = 1'b0;
      exp_q.delete();
      flush_fifo();
      tick();
      tick();
      rrst = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      rrst       = 1'b0;
      rd_req     = 1'b0;
      rd_len     = '0;
      dout_ready = 1'b1;
      tick();
      tick();
      rrst = 1'b1;
      tick();

      // 1: basic 4-word burst, full throughput
      clear_stats();
      issue(4, 32'hA0, 4);
      wait_idle("t1");
      check("t1_r_en_count", r_en_cnt, 4);
      check("t1_r_en_consecutive", max_run, 4);
      check("t1_busy_cycles", busy_cnt, 6);
      check("t1_word_spacing", last_xfer - first_xfer, 3);
      check("t1_words", xfer_cnt, 4);

      // 2: zero and oversize lengths both mean a full burst
      clear_stats();
      issue(0, 32'hB0, 6);
      wait_idle("t2a");
      check("t2_len0_r_en", r_en_cnt, 4);
      check("t2_len0_words", xfer_cnt, 4);
      flush_fifo();
      clear_stats();
      issue(6, 32'hB8, 6);
      wait_idle("t2b");
      check("t2_len6_words", xfer_cnt, 4);
      flush_fifo();

      // 3: FIFO empty for 5 cycles after the second read
      clear_stats();
      issue(4, 32'hC0, 4);
      n = 0;
      while (r_en_cnt < 2 && n < 20) begin
         tick();
         n++;
      end
      check("t3_reach_two_reads", (r_en_cnt >= 2) ? 1 : 0, 1);
      force_empty = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("t3_r_en_stalled", r_en_cnt, 2);
      force_empty = 1'b0;
      wait_idle("t3");
      check("t3_r_en_total", r_en_cnt, 4);

      // 4: downstream stalled for 10 cycles from the request
      clear_stats();
      dout_ready = 1'b0;
      issue(4, 32'hD0, 4);
      tick();
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         check("t4_valid_held", int'(dout_valid), 1);
         check("t4_dout_held", int'(dout), 32'hD0);
         tick();
      end
      check("t4_r_en_stopped", r_en_cnt, 2);
      dout_ready = 1'b1;
      wait_idle("t4");
      check("t4_r_en_total", r_en_cnt, 4);

      // 5: reset after two of four words
      clear_stats();
      issue(4, 32'hE0, 4);
      n = 0;
      while (xfer_cnt < 2 && n < 20) begin
         tick();
         n++;
      end
      check("t5_two_delivered", xfer_cnt, 2);
      pulse_reset();
      clear_stats();
      issue(1, 32'hF0, 2);
      wait_idle("t5");
      check("t5_single_words", xfer_cnt, 1);
      check("t5_single_r_en", r_en_cnt, 1);
      flush_fifo();

`ifdef RD_CONSUMER_STATS_EN
      // 6: delivery counter over three 3-word bursts
      pulse_reset();
      issue(3, 32'h10, 3);
      wait_idle("t6a");
      issue(3, 32'h20, 3);
      wait_idle("t6b");
      issue(3, 32'h30, 3);
      wait_idle("t6c");
      check("t6_words_delivered", int'(words_delivered), 9);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
